program_sequencer_ctrl: RTL

//  Sequences the program memory address for the 8-bit microcontroller core.

---
 rtl/program_sequencer_ctrl.sv | 105 ++++++++++
 1 files changed

// File: rtl/program_sequencer_ctrl.sv
// program_sequencer_ctrl: program-memory address sequencer with return stack, fetch stall and fault lock.
// Ports:
//   clk, sync_reset_n          clock and synchronous active-low reset
//   jmp, jmp_nz, dont_jmp      jump strobes; dont_jmp (zero flag) suppresses jmp_nz
//   call, ret, ir_nibble       subroutine strobes and low-nibble target
//   pm_ready                   program memory data valid for pm_addr
//   pm_addr                    combinational next fetch address
//   pc, sp, state              registered address, stack occupancy, 00 RUN 01 STALL 10 FAULT
//   hold                       freeze request to the decoder
//   stack_overflow/underflow   sticky misuse flags
module program_sequencer_ctrl #(
   parameter int PC_W        = 8,
   parameter int STACK_DEPTH = 4,
   parameter int SP_W        = 3
) (
   input  logic            clk,
   input  logic            sync_reset_n,
   input  logic            jmp,
   input  logic            jmp_nz,
   input  logic            dont_jmp,
   input  logic            call,
   input  logic            ret,
   input  logic [3:0]      ir_nibble,
   input  logic            pm_ready,
   output logic [PC_W-1:0] pm_addr,
   output logic [PC_W-1:0] pc,
   output logic            hold,
   output logic [SP_W-1:0] sp,
   output logic            stack_overflow,
   output logic            stack_underflow,
   output logic [1:0]      state
);
   localparam int IDX_W = $clog2(STACK_DEPTH);
   typedef enum logic [1:0] {RUN = 2'b00, STALL = 2'b01, FAULT = 2'b10} state_t;
   state_t          r_state, w_next;
   logic [PC_W-1:0] r_pc, w_addr, w_tgt, w_inc;
   logic [SP_W-1:0] r_sp, w_sp_m1;
   logic [PC_W-1:0] r_stack [STACK_DEPTH];
   logic            r_ovf, r_unf, w_push, w_pop, w_set_ovf, w_set_unf, w_act, w_full, w_empty;
   assign w_tgt   = {r_pc[PC_W-1:4], ir_nibble};
   assign w_inc   = r_pc + 1'b1;
   assign w_sp_m1 = r_sp - 1'b1;
   assign w_full  = r_sp == SP_W'(STACK_DEPTH);
   assign w_empty = r_sp == '0;
   // strobes only act in RUN with the fetch completing; otherwise the pc is held
   assign w_act   = (r_state == RUN) && pm_ready;
   always_comb begin
      w_addr    = r_pc;
      w_next    = r_state;
      w_push    = 1'b0;
      w_pop     = 1'b0;
      w_set_ovf = 1'b0;
      w_set_unf = 1'b0;
      if (r_state == RUN && !pm_ready) begin
         w_next = STALL;
      end else if (r_state == STALL) begin
         w_next = pm_ready ? RUN : STALL;
      end else if (w_act) begin
         if (jmp) begin
            w_addr = w_tgt;
         end else if (jmp_nz) begin
            w_addr = dont_jmp ? w_inc : w_tgt;
         end else if (call) begin
            w_addr    = w_full ? r_pc : w_tgt;
            w_push    = !w_full;
            w_set_ovf = w_full;
            w_next    = w_full ? FAULT : RUN;
         end else if (ret) begin
            w_addr    = w_empty ? r_pc : r_stack[w_sp_m1[IDX_W-1:0]];
            w_pop     = !w_empty;
            w_set_unf = w_empty;
            w_next    = w_empty ? FAULT : RUN;
         end else begin
            w_addr = w_inc;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (!sync_reset_n) begin
         r_pc    <= '0;
         r_sp    <= '0;
         r_state <= RUN;
         r_ovf   <= 1'b0;
         r_unf   <= 1'b0;
      end else begin
         r_pc    <= w_addr;
         r_state <= w_next;
         r_ovf   <= r_ovf | w_set_ovf;
         r_unf   <= r_unf | w_set_unf;
         if (w_push) r_sp <= r_sp + 1'b1;
         else if (w_pop) r_sp <= w_sp_m1;
      end
   end
   // stack contents need no reset; occupancy is tracked by r_sp
   always_ff @(posedge clk) begin
      if (sync_reset_n && w_push) r_stack[r_sp[IDX_W-1:0]] <= w_inc;
   end
   assign pm_addr         = sync_reset_n ? w_addr : '0;
   assign hold            = sync_reset_n && (r_state != RUN || !pm_ready);
   assign pc              = r_pc;
   assign sp              = r_sp;
   assign stack_overflow  = r_ovf;
   assign stack_underflow = r_unf;
   assign state           = r_state;
endmodule
